// File: rtl/sample_pacer.sv
// sample_pacer
// -----------------------------------------------------------------------------
// Transmit-side pacer for a 1-in-PERIOD downstream sampler. Words arrive at
// full clock rate through a valid/ready handshake and are buffered in a small
// FIFO. One word is released every PERIOD cycles and held stable on out_data
// for the whole slot, so the slow consumer never misses or duplicates a sample.
//
// Parameters:
//   WIDTH   data word width in bits
//   PERIOD  cycles per output slot, 2..256
//   DEPTH   FIFO entries, power of two, >= 2
//
// Ports:
//   clk           system clock, rising-edge active
//   reset         asynchronous active-high reset
//   in_data       producer word
//   in_valid      producer word valid
//   in_ready      FIFO not full (registered)
//   underrun_clr  synchronous clear of the sticky underrun flag
//   out_data      paced word, stable for a whole slot
//   out_valid     out_data was released at the most recent slot boundary
//   out_tick      one-cycle pulse in the first cycle of every slot
//   level         FIFO occupancy, 0..DEPTH
//   underrun      sticky: a slot boundary found the FIFO empty after streaming began
// -----------------------------------------------------------------------------
module sample_pacer #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 5,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     underrun_clr,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     out_tick,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    // Registered state
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [LVL_W-1:0] level_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             out_tick_r;
    logic             underrun_r;
    logic             primed_r;
    logic             in_ready_r;

    // Combinational decisions
    logic             boundary_s;
    logic             push_s;
    logic             pop_s;
    logic             starved_s;
    logic [LVL_W-1:0] level_next_s;
    logic             out_valid_next_s;
    logic             underrun_next_s;

    // A boundary is the last cycle of a slot; the pop decision looks only at
    // the occupancy before any same-cycle push, so a word landing on a
    // boundary waits for the next one.
    assign boundary_s = (cnt_r == CNT_LAST);
    assign push_s     = in_valid & in_ready_r;
    assign pop_s      = boundary_s & (level_r != {LVL_W{1'b0}});
    assign starved_s  = boundary_s & (level_r == {LVL_W{1'b0}});

    // Next occupancy, output-valid and sticky underrun flag
    always_comb begin
        level_next_s     = level_r;
        out_valid_next_s = out_valid_r;
        underrun_next_s  = underrun_r;

        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase

        if (pop_s) begin
            out_valid_next_s = 1'b1;
        end else if (starved_s) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end

        // A set event on the same cycle as a clear request wins.
        if (starved_s && primed_r) begin
            underrun_next_s = 1'b1;
        end else if (underrun_clr) begin
            underrun_next_s = 1'b0;
        end else begin
            underrun_next_s = underrun_r;
        end
    end

    // Free-running slot counter and the tick that marks the first slot cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            out_tick_r <= 1'b0;
        end else begin
            cnt_r      <= boundary_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
            out_tick_r <= boundary_s;
        end
    end

    // FIFO storage write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[tail_r] <= in_data;
        end
    end

    // FIFO pointers, occupancy and registered ready; pointers wrap modulo DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            level_r    <= {LVL_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            level_r    <= level_next_s;
            // Ready follows the registered occupancy, so it rises only in the
            // cycle after a pop frees a full FIFO (no bypass path).
            in_ready_r <= (level_next_s != LVL_FULL);
        end
    end

    // Output stage: latch the head word at a boundary and track streaming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            underrun_r  <= 1'b0;
            primed_r    <= 1'b0;
        end else begin
            if (pop_s) begin
                out_data_r <= mem_r[head_r];
                primed_r   <= 1'b1;
            end
            out_valid_r <= out_valid_next_s;
            underrun_r  <= underrun_next_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_tick  = out_tick_r;
    assign level     = level_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_sample_pacer.sv
// tb_sample_pacer
// -----------------------------------------------------------------------------
// Directed bench for sample_pacer (WIDTH=8, PERIOD=5, DEPTH=4). Accepted input
// words are pushed into an expected-word queue; a monitor on the falling edge
// pops and compares whenever a new word is presented (out_tick with out_valid)
// and checks that the word stays stable for the rest of its slot. Timing,
// level, ready and underrun expectations are hand-derived cycle numbers,
// counted in rising edges since reset release.
// -----------------------------------------------------------------------------
module tb_sample_pacer;

    localparam int WIDTH  = 8;
    localparam int PERIOD = 5;
    localparam int DEPTH  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             underrun_clr = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_tick;
    logic [2:0]       level;
    logic             underrun;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] held;
    logic             acc;
    logic [WIDTH-1:0] nxt;
    int               guard;

    sample_pacer #(
        .WIDTH (WIDTH),
        .PERIOD(PERIOD),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .underrun_clr(underrun_clr),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_tick    (out_tick),
        .level       (level),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance one rising edge, land 1 time unit after it.
    task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic c, output logic a);
        in_valid     = v;
        in_data      = d;
        underrun_clr = c;
        a = v & in_ready;
        @(posedge clk);
        if (a) exp_q.push_back(d);
        #1;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, a);
    endtask

    // Assert reset asynchronously, check reset values, release on a falling edge.
    task automatic do_reset();
        in_valid     = 1'b0;
        in_data      = 8'h00;
        underrun_clr = 1'b0;
        reset        = 1'b1;
        #1;
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_tick", out_tick, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_underrun", underrun, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: compare each newly presented word, then check it holds.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_tick && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %02h expected no word", out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    chk("sb_word", out_data, exp_word);
                end
                held = out_data;
            end else if (out_valid) begin
                chk("sb_hold", out_data, held);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        do_reset();

        // Idle: tick every 5th cycle, nothing else moves
        for (int n = 1; n <= 20; n++) begin
            idle(1);
            chk("idle_tick", out_tick, (n % PERIOD) == 0);
        end
        chk("idle_out_valid", out_valid, 1'b0);
        chk("idle_underrun", underrun, 1'b0);
        chk("idle_level", level, 3'd0);
        chk("idle_in_ready", in_ready, 1'b1);

        // Three words from cnt=0 (cycle 20); released at cycles 25, 30, 35
        tick(1'b1, 8'h11, 1'b0, acc);
        tick(1'b1, 8'h22, 1'b0, acc);
        tick(1'b1, 8'h33, 1'b0, acc);
        chk("burst_level", level, 3'd3);
        idle(2);                                   // cycle 25
        chk("burst_first", out_data, 8'h11);
        chk("burst_first_valid", out_valid, 1'b1);
        idle(14);                                  // cycle 39
        chk("burst_last", out_data, 8'h33);
        chk("burst_no_underrun_yet", underrun, 1'b0);
        idle(1);                                   // cycle 40
        chk("burst_empty_valid", out_valid, 1'b0);
        chk("burst_underrun", underrun, 1'b1);
        chk("burst_hold_data", out_data, 8'h33);

        // Underrun clear on a non-boundary cycle (cycle 41)
        idle(1);
        tick(1'b0, 8'h00, 1'b1, acc);              // cycle 42
        chk("clr_plain", underrun, 1'b0);
        idle(3);                                   // cycle 45, boundary 44 starved
        chk("clr_reset_again", underrun, 1'b1);
        idle(4);                                   // cycle 49 is a starved boundary
        tick(1'b0, 8'h00, 1'b1, acc);              // cycle 50
        chk("clr_set_wins", underrun, 1'b1);
        tick(1'b0, 8'h00, 1'b1, acc);              // cycle 51
        chk("clr_final", underrun, 1'b0);

        // Continuous valid from cycle 51: fill to 4, then one word per slot
        nxt = 8'h01;
        for (int c = 51; c < 72; c++) begin
            if (c == 56) begin
                chk("full_level", level, 3'd4);
                chk("full_ready", in_ready, 1'b0);
            end
            if (c == 59) chk("full_ready_boundary", in_ready, 1'b0);
            if (c == 60) begin
                chk("after_pop_ready", in_ready, 1'b1);
                chk("after_pop_level", level, 3'd3);
            end
            if (c == 61) chk("refill_level", level, 3'd4);
            tick(1'b1, nxt, 1'b0, acc);
            if (acc) nxt = nxt + 8'h01;
        end
        chk("accepted_count", nxt, 8'h09);
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            idle(1);
            guard++;
        end
        chk("drain_done", exp_q.size(), 0);

        // Push on an empty boundary with primed=0
        do_reset();
        idle(4);                                   // cycle 4: boundary
        tick(1'b1, 8'hAA, 1'b0, acc);              // cycle 5
        chk("bnd_no_pop_valid", out_valid, 1'b0);
        chk("bnd_level", level, 3'd1);
        chk("bnd_tick", out_tick, 1'b1);
        chk("bnd_underrun", underrun, 1'b0);
        idle(5);                                   // cycle 10
        chk("bnd_release", out_data, 8'hAA);
        chk("bnd_release_valid", out_valid, 1'b1);
        chk("bnd_level_after", level, 3'd0);

        // Mid-slot reset with level=3 and out_data=0x5C
        tick(1'b1, 8'h5C, 1'b0, acc);
        tick(1'b1, 8'h61, 1'b0, acc);
        tick(1'b1, 8'h62, 1'b0, acc);
        tick(1'b1, 8'h63, 1'b0, acc);              // cycle 14
        chk("pre_rst_full", level, 3'd4);
        chk("pre_rst_ready", in_ready, 1'b0);
        idle(2);                                   // cycle 16, cnt=1
        chk("pre_rst_level", level, 3'd3);
        chk("pre_rst_data", out_data, 8'h5C);
        #2;
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            idle(1);
            chk("post_rst_tick", out_tick, n == 5);
        end
        chk("post_rst_valid", out_valid, 1'b0);
        chk("post_rst_underrun", underrun, 1'b0);
        chk("post_rst_level", level, 3'd0);
        chk("post_rst_ready", in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_pacer.md
Name: sample_pacer

Overview:
- Transmit-side counterpart of the 1-in-PERIOD output sampler used in the convolution datapath.
- Accepts words at full clock rate through a valid/ready handshake and buffers them in a small FIFO.
- Releases one word every PERIOD cycles and holds each word stable for the whole period, so a downstream 1-in-PERIOD sampler never misses or duplicates a sample.
- Sits between the convolution core output and the slow-rate consumer.

Parameters:
- WIDTH, 8, data word width in bits.
- PERIOD, 5, cycles per output slot; legal range 2..256.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word from the producer.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a word; equals !full.
- underrun_clr  input  1  synchronous clear of the underrun flag.
- out_data  output  WIDTH  paced word; held stable for PERIOD cycles.
- out_valid  output  1  out_data holds a word released at the most recent slot boundary.
- out_tick  output  1  one-cycle pulse in the first cycle of each slot.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- underrun  output  1  sticky flag: a slot boundary found the FIFO empty after streaming began.

Behaviour:
- Reset (async assert, any time, including mid-operation):
  - slot counter cnt=0, FIFO empty, level=0.
  - out_data=0, out_valid=0, out_tick=0, underrun=0, primed=0.
  - in_ready=1 while reset is deasserted with the FIFO empty.
- Slot counter:
  - cnt runs 0..PERIOD-1 and wraps; it is free-running from reset release and independent of the data flow.
  - A boundary is a cycle with cnt==PERIOD-1.
- Push: occurs when in_valid && in_ready. The word is written at the tail; level increments.
- Pop at a boundary with level>0:
  - out_data <= head, head advances, out_valid <= 1, primed <= 1.
  - level decrements, or stays unchanged if a push happens in the same cycle.
- Boundary with level==0:
  - out_data holds its last value, out_valid <= 0.
  - If primed==1, underrun <= 1.
- out_tick is registered high for exactly the cycle after each boundary, i.e. the cycle where cnt==0. It pulses every slot, with or without data.
- Full FIFO: in_ready=0, so there is no push even if a pop occurs the same cycle. There is no bypass; in_ready rises the cycle after the pop.
- Empty FIFO with a push on a boundary cycle:
  - The pop decision uses the pre-push level, so there is no pop.
  - The word is released at the next boundary.
- Latency:
  - A word pushed into an empty FIFO in a cycle with cnt=k (k<PERIOD-1) appears on out_data at the edge ending cnt=PERIOD-1 of the same slot.
  - Minimum latency is 1 cycle; maximum is PERIOD cycles.
- underrun priority: underrun_clr clears the flag, but a simultaneous set event wins and the flag stays 1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level is a separate counter.
- Data order is strictly FIFO; no word is dropped or duplicated while in_ready is honoured.

Test Plan:
- Reset then idle 20 cycles:
  - out_tick pulses at cycles 5, 10, 15, 20 after reset release.
  - out_valid=0, underrun=0, level=0, in_ready=1.
- Push 0x11, 0x22, 0x33 on consecutive cycles starting at cnt=0:
  - out_data=0x11 from the cycle with cnt=0 of the next slot, then 0x22 and 0x33, each held 5 cycles.
  - Then out_valid=0 and underrun=1.
- Hold in_valid=1 continuously with data 0x01, 0x02, …:
  - level reaches 4 and in_ready=0.
  - Afterwards, one word is accepted per slot in the cycle after each pop.
  - Output sequence is 0x01, 0x02, 0x03, … with no gaps or repeats.
- Push 0xAA exactly at a boundary cycle with the FIFO empty:
  - No pop that slot.
  - 0xAA appears one full slot later; underrun is unaffected if primed=0.
- Force underrun=1, then pulse underrun_clr on a non-boundary cycle:
  - underrun=0 next cycle.
  - Repeat with the pulse on an empty boundary: underrun stays 1.
- Assert reset mid-slot with level=3 and out_data=0x5C:
  - All outputs return to reset values immediately.
  - After release, cnt restarts at 0 and the first out_tick comes 5 cycles later.
